// File: rtl/game_pkg.sv
// Shared definitions for the object motion engine.
//   state_e     : sweep controller states
//   KEY_*       : USB HID keycodes the engine reacts to
package game_pkg;

    typedef enum logic [0:0] {StIdle, StSweep} state_e;

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

endpackage

// File: rtl/motion_step.sv
// Combinational next-state for one object.
//   mode          : 0 key-drive/bounce, 1 gravity/flap
//   is_sel, flap  : object is keyboard-selected / pending flap for it
//   keycode       : captured keycode
//   x, y, vx, vy  : current state
//   nx, ny, nvx, nvy, hit : next state and boundary-contact flag
module motion_step
    import game_pkg::*;
#(
    parameter int COORD_W  = 10,
    parameter int VEL_W    = 8,
    parameter int X_MAX    = 639,
    parameter int Y_MAX    = 479,
    parameter int STEP     = 2,
    parameter int GRAVITY  = 1,
    parameter int FLAP_VEL = -8,
    parameter int MAX_FALL = 10
) (
    input  logic               mode,
    input  logic               is_sel,
    input  logic               flap,
    input  logic [7:0]         keycode,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [VEL_W-1:0]   vx,
    input  logic [VEL_W-1:0]   vy,
    output logic [COORD_W-1:0] nx,
    output logic [COORD_W-1:0] ny,
    output logic [VEL_W-1:0]   nvx,
    output logic [VEL_W-1:0]   nvy,
    output logic               hit
);

    // Two guard bits so pos+v can be seen going negative or past MAX.
    localparam int SW = COORD_W + 2;
    localparam logic signed [SW-1:0]    XMAX_S = SW'(X_MAX);
    localparam logic signed [SW-1:0]    YMAX_S = SW'(Y_MAX);
    localparam logic signed [VEL_W-1:0] STEP_V = VEL_W'(STEP);
    localparam logic signed [VEL_W-1:0] FLAP_V = VEL_W'(FLAP_VEL);
    localparam logic signed [VEL_W-1:0] FALL_V = VEL_W'(MAX_FALL);
    localparam logic signed [VEL_W:0]   GRAV_E = (VEL_W + 1)'(GRAVITY);
    localparam logic signed [VEL_W:0]   FALL_E = (VEL_W + 1)'(MAX_FALL);

    logic signed [VEL_W-1:0] vx_t, vy_t;
    logic signed [VEL_W:0]   vy_g;
    logic signed [SW-1:0]    px, py;

    always_comb begin
        vx_t = vx;
        vy_t = vy;
        vy_g = '0;
        if (!mode) begin
            if (is_sel) begin
                case (keycode)
                    KEY_W:   vy_t = -STEP_V;
                    KEY_S:   vy_t = STEP_V;
                    KEY_A:   vx_t = -STEP_V;
                    KEY_D:   vx_t = STEP_V;
                    default: ;
                endcase
            end
        end else begin
            vy_g = $signed({vy[VEL_W-1], vy}) + GRAV_E;
            if (vy_g > FALL_E) vy_t = FALL_V;
            else               vy_t = vy_g[VEL_W-1:0];
            if (is_sel && flap) vy_t = FLAP_V;
        end

        px = $signed({2'b00, x}) + $signed({{(SW - VEL_W){vx_t[VEL_W-1]}}, vx_t});
        py = $signed({2'b00, y}) + $signed({{(SW - VEL_W){vy_t[VEL_W-1]}}, vy_t});

        nx  = px[COORD_W-1:0];
        ny  = py[COORD_W-1:0];
        nvx = vx_t;
        nvy = vy_t;
        hit = 1'b0;

        if (!mode) begin
            if (px > XMAX_S) begin
                nx = COORD_W'(X_MAX); nvx = -vx_t; hit = 1'b1;
            end else if (px[SW-1]) begin
                nx = '0;              nvx = -vx_t; hit = 1'b1;
            end
            if (py > YMAX_S) begin
                ny = COORD_W'(Y_MAX); nvy = -vy_t; hit = 1'b1;
            end else if (py[SW-1]) begin
                ny = '0;              nvy = -vy_t; hit = 1'b1;
            end
        end else begin
            // Horizontal clamps silently; only the floor counts as contact.
            if (px > XMAX_S)    nx = COORD_W'(X_MAX);
            else if (px[SW-1])  nx = '0;
            if (py >= YMAX_S) begin
                ny = COORD_W'(Y_MAX); nvy = '0; hit = 1'b1;
            end else if (py[SW-1]) begin
                ny = '0;              nvy = '0;
            end
        end
    end

endmodule

// File: rtl/object_motion_engine.sv
// Per-frame motion update for N_OBJ sprites.
//   Clk, Reset_n        : clock, async active-low reset
//   vs                  : VGA vsync; its rising edge requests one update sweep
//   keycode, mode, sel  : keyboard input, motion mode, controlled object
//   load_*              : valid/ready write of one object's position/velocity
//   obj_x, obj_y        : packed positions, object 0 in LSBs
//   obj_hit             : sticky boundary-contact flags
//   busy                : sweep in progress
module object_motion_engine
    import game_pkg::*;
#(
    parameter int N_OBJ    = 4,
    parameter int COORD_W  = 10,
    parameter int VEL_W    = 8,
    parameter int X_MAX    = 639,
    parameter int Y_MAX    = 479,
    parameter int STEP     = 2,
    parameter int GRAVITY  = 1,
    parameter int FLAP_VEL = -8,
    parameter int MAX_FALL = 10,
    localparam int IDX_W   = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       vs,
    input  logic [7:0]                 keycode,
    input  logic                       mode,
    input  logic [IDX_W-1:0]           sel,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [IDX_W-1:0]           load_idx,
    input  logic [COORD_W-1:0]         load_x,
    input  logic [COORD_W-1:0]         load_y,
    input  logic [VEL_W-1:0]           load_vx,
    input  logic [VEL_W-1:0]           load_vy,
    output logic [N_OBJ*COORD_W-1:0]   obj_x,
    output logic [N_OBJ*COORD_W-1:0]   obj_y,
    output logic [N_OBJ-1:0]           obj_hit,
    output logic                       busy
);

    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_OBJ - 1);
    localparam logic [COORD_W-1:0] X_RST    = COORD_W'(X_MAX / 2);
    localparam logic [COORD_W-1:0] Y_RST    = COORD_W'(Y_MAX / 2);

    state_e             state_q, state_d;
    logic               vs_q, tick;
    logic               pending_q, pending_d, start, upd, upd_sel, load_acc;
    logic [IDX_W-1:0]   idx_q, idx_d, sel_q;
    logic               mode_q;
    logic [7:0]         key_q, key_prev_q;
    logic               flap_q, flap_d, flap_evt;

    logic [COORD_W-1:0] x_q  [N_OBJ];
    logic [COORD_W-1:0] y_q  [N_OBJ];
    logic [VEL_W-1:0]   vx_q [N_OBJ];
    logic [VEL_W-1:0]   vy_q [N_OBJ];
    logic [N_OBJ-1:0]   hit_q;

    logic [COORD_W-1:0] s_nx, s_ny;
    logic [VEL_W-1:0]   s_nvx, s_nvy;
    logic               s_hit;

    assign tick     = vs & ~vs_q;
    assign flap_evt = (keycode == KEY_SPACE) && (key_prev_q != KEY_SPACE);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        start      = 1'b0;
        upd        = 1'b0;
        // Held low through reset so no load is offered while state is forced.
        load_ready = (state_q == StIdle) && Reset_n;
        busy       = (state_q == StSweep);
        load_acc   = load_valid && load_ready;
        unique case (state_q)
            StIdle: begin
                if (pending_q && !load_acc) begin
                    state_d = StSweep;
                    idx_d   = '0;
                    start   = 1'b1;
                end
            end
            StSweep: begin
                upd = 1'b1;
                if (idx_q == LAST_IDX) state_d = StIdle;
                else                   idx_d   = idx_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase
        // A tick on the entry cycle re-arms pending for a back-to-back sweep.
        pending_d = (pending_q & ~start) | tick;
        upd_sel   = upd && (idx_q == sel_q);
        flap_d    = flap_evt | (flap_q & ~upd_sel);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= StIdle;
            vs_q       <= 1'b1;
            pending_q  <= 1'b0;
            idx_q      <= '0;
            sel_q      <= '0;
            mode_q     <= 1'b0;
            key_q      <= '0;
            key_prev_q <= '0;
            flap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vs_q       <= vs;
            pending_q  <= pending_d;
            idx_q      <= idx_d;
            key_prev_q <= keycode;
            flap_q     <= flap_d;
            if (start) begin
                sel_q  <= sel;
                mode_q <= mode;
                key_q  <= keycode;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < N_OBJ; i++) begin
                x_q[i]  <= X_RST;
                y_q[i]  <= Y_RST;
                vx_q[i] <= '0;
                vy_q[i] <= '0;
            end
            hit_q <= '0;
        end else if (load_acc) begin
            x_q[load_idx]   <= load_x;
            y_q[load_idx]   <= load_y;
            vx_q[load_idx]  <= load_vx;
            vy_q[load_idx]  <= load_vy;
            hit_q[load_idx] <= 1'b0;
        end else if (upd) begin
            x_q[idx_q]  <= s_nx;
            y_q[idx_q]  <= s_ny;
            vx_q[idx_q] <= s_nvx;
            vy_q[idx_q] <= s_nvy;
            if (s_hit) hit_q[idx_q] <= 1'b1;
        end
    end

    motion_step #(
        .COORD_W  (COORD_W),
        .VEL_W    (VEL_W),
        .X_MAX    (X_MAX),
        .Y_MAX    (Y_MAX),
        .STEP     (STEP),
        .GRAVITY  (GRAVITY),
        .FLAP_VEL (FLAP_VEL),
        .MAX_FALL (MAX_FALL)
    ) u_step (
        .mode    (mode_q),
        .is_sel  (idx_q == sel_q),
        .flap    (flap_q),
        .keycode (key_q),
        .x       (x_q[idx_q]),
        .y       (y_q[idx_q]),
        .vx      (vx_q[idx_q]),
        .vy      (vy_q[idx_q]),
        .nx      (s_nx),
        .ny      (s_ny),
        .nvx     (s_nvx),
        .nvy     (s_nvy),
        .hit     (s_hit)
    );

    for (genvar g = 0; g < N_OBJ; g++) begin : g_pack
        assign obj_x[g*COORD_W +: COORD_W] = x_q[g];
        assign obj_y[g*COORD_W +: COORD_W] = y_q[g];
    end
    assign obj_hit = hit_q;

endmodule

// File: tb/tb_object_motion_engine.sv
module tb_object_motion_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vs;
    logic [7:0]  keycode;
    logic        mode;
    logic [1:0]  sel;
    logic        load_valid;
    logic        load_ready;
    logic [1:0]  load_idx;
    logic [9:0]  load_x, load_y;
    logic [7:0]  load_vx, load_vy;
    logic [39:0] obj_x, obj_y;
    logic [3:0]  obj_hit;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    object_motion_engine dut (
        .Clk        (clk),
        .Reset_n    (rst_n),
        .vs         (vs),
        .keycode    (keycode),
        .mode       (mode),
        .sel        (sel),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_idx   (load_idx),
        .load_x     (load_x),
        .load_y     (load_y),
        .load_vx    (load_vx),
        .load_vy    (load_vy),
        .obj_x      (obj_x),
        .obj_y      (obj_y),
        .obj_hit    (obj_hit),
        .busy       (busy)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int px(input int i);
        return int'(obj_x[i*10 +: 10]);
    endfunction

    function automatic int py(input int i);
        return int'(obj_y[i*10 +: 10]);
    endfunction

    // One vs pulse; returns the number of busy cycles seen (0 on timeout).
    task automatic frame(output int nb);
        int t;
        nb = 0;
        t  = 0;
        @(negedge clk); vs = 1'b1;
        @(negedge clk); vs = 1'b0;
        while (!busy && t < 10) begin @(negedge clk); t++; end
        while (busy && t < 40) begin nb++; @(negedge clk); t++; end
    endtask

    task automatic load_obj(input int idx, input int x, input int y, input int vx, input int vy);
        int t;
        t = 0;
        @(negedge clk);
        load_valid = 1'b1;
        load_idx   = 2'(idx);
        load_x     = 10'(x);
        load_y     = 10'(y);
        load_vx    = 8'(vx);
        load_vy    = 8'(vy);
        while (!load_ready && t < 20) begin @(negedge clk); t++; end
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    initial begin
        int nb;
        int t;
        rst_n = 1'b0; vs = 1'b0; keycode = 8'h00; mode = 1'b0; sel = 2'd0;
        load_valid = 1'b0; load_idx = '0; load_x = '0; load_y = '0; load_vx = '0; load_vy = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_load_ready", int'(load_ready), 0);
        check("rst_hit", int'(obj_hit), 0);
        for (int i = 0; i < 4; i++) begin
            check("rst_x", px(i), 319);
            check("rst_y", py(i), 239);
        end
        rst_n = 1'b1;
        nb = 0;
        repeat (5) begin @(negedge clk); nb += int'(busy); end
        check("idle_after_rst_busy", nb, 0);
        check("idle_load_ready", int'(load_ready), 1);

        // One frame, all velocities zero
        frame(nb);
        check("sweep_len", nb, 4);
        for (int i = 0; i < 4; i++) begin
            check("still_x", px(i), 319);
            check("still_y", py(i), 239);
        end

        // Key-drive right on object 1 for three frames
        mode = 1'b0; sel = 2'd1; keycode = 8'h07;
        repeat (3) begin
            frame(nb);
            check("sweep_len_m0", nb, 4);
        end
        check("obj1_x_right", px(1), 325);
        check("obj1_y", py(1), 239);
        check("obj0_x", px(0), 319);
        check("obj2_x", px(2), 319);
        check("obj3_x", px(3), 319);
        keycode = 8'h00;

        // Bounce at right edge
        load_obj(2, 638, 239, 2, 0);
        check("obj2_loaded_x", px(2), 638);
        check("obj2_hit_clear", int'(obj_hit[2]), 0);
        frame(nb);
        check("obj2_clamp_x", px(2), 639);
        check("obj2_hit_set", int'(obj_hit[2]), 1);
        frame(nb);
        check("obj2_bounce_x", px(2), 637);
        check("obj2_hit_sticky", int'(obj_hit[2]), 1);
        check("obj1_x_cont", px(1), 329);

        // Load in the same cycle as a vs edge
        @(negedge clk);
        vs = 1'b1; load_valid = 1'b1; load_idx = 2'd3;
        load_x = 10'd10; load_y = 10'd20; load_vx = 8'(-3); load_vy = 8'd5;
        @(negedge clk);
        vs = 1'b0; load_valid = 1'b0;
        check("ld_vs_x", px(3), 10);
        check("ld_vs_busy_early", int'(busy), 0);
        @(negedge clk);
        check("ld_vs_busy", int'(busy), 1);
        t = 0;
        while (busy && t < 20) begin @(negedge clk); t++; end
        check("ld_vs_done", int'(busy), 0);
        check("ld_vs_sweep_x", px(3), 7);
        check("ld_vs_sweep_y", py(3), 25);
        check("ld_vs_hit", int'(obj_hit[3]), 0);

        // Gravity/flap with space held
        mode = 1'b1; sel = 2'd0;
        load_obj(0, 319, 100, 0, 0);
        @(negedge clk); keycode = 8'h2C;
        frame(nb);
        check("flap_y1", py(0), 92);
        check("flap_x1", px(0), 319);
        frame(nb);
        check("flap_y2_held", py(0), 85);
        check("grav_obj3_x", px(3), 1);
        check("grav_obj3_y", py(3), 38);

        // Floor contact; left edge clamps without contact
        load_obj(2, 100, 478, 0, 5);
        check("floor_hit_clear", int'(obj_hit[2]), 0);
        frame(nb);
        check("floor_y", py(2), 479);
        check("floor_hit", int'(obj_hit[2]), 1);
        check("flap_y3", py(0), 79);
        check("clamp_obj3_x", px(3), 0);
        check("clamp_obj3_nohit", int'(obj_hit[3]), 0);

        // Reset during cycle 2 of a sweep
        mode = 1'b0; keycode = 8'h00;
        @(negedge clk); vs = 1'b1;
        @(negedge clk); vs = 1'b0;
        t = 0;
        while (!busy && t < 10) begin @(negedge clk); t++; end
        check("midrst_sweep_started", int'(busy), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_load_ready", int'(load_ready), 0);
        check("midrst_hit", int'(obj_hit), 0);
        check("midrst_x0", px(0), 319);
        check("midrst_y2", py(2), 239);
        check("midrst_x3", px(3), 319);
        @(negedge clk);
        rst_n = 1'b1;
        nb = 0;
        repeat (8) begin @(negedge clk); nb += int'(busy); end
        check("midrst_no_sweep", nb, 0);
        frame(nb);
        check("post_rst_sweep_len", nb, 4);
        check("post_rst_x1", px(1), 319);
        check("post_rst_y0", py(0), 239);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/object_motion_engine.md
OBJECT_MOTION_ENGINE -- requirements
Module: object_motion_engine

Interface
REQ-001 Parameters SHALL be: N_OBJ, default 4, object count (1..8); COORD_W, default 10, coordinate width; VEL_W, default 8, signed velocity width; X_MAX, default 639; Y_MAX, default 479; STEP, default 2, key-drive speed; GRAVITY, default 1; FLAP_VEL, default -8; MAX_FALL, default 10.
REQ-002 Clk  in  1  system clock (50 MHz); all logic on rising edge.
REQ-003 Reset_n  in  1  reset, asynchronous assert, active-low.
REQ-004 vs  in  1  raw VGA vertical sync, synchronous to Clk.
REQ-005 keycode  in  8  USB HID keycode from the SoC PIO.
REQ-006 mode  in  1  0 = key-drive/bounce, 1 = gravity/flap.
REQ-007 sel  in  clog2(N_OBJ)  index of the object the keyboard controls.
REQ-008 load_valid, load_ready  in/out  1  load handshake.
REQ-009 load_idx, load_x, load_y, load_vx, load_vy  in  clog2(N_OBJ)/COORD_W/COORD_W/VEL_W/VEL_W  load payload.
REQ-010 obj_x, obj_y  out  N_OBJ x COORD_W  current positions, packed, object 0 in LSBs.
REQ-011 obj_hit  out  N_OBJ  sticky boundary-contact flags.
REQ-012 busy  out  1  high while an update sweep runs.

Function
REQ-013 A frame tick SHALL be the rising edge of vs, detected with a registered copy of vs; a tick SHALL set a pending flag.
REQ-014 FSM states SHALL be IDLE and SWEEP; IDLE->SWEEP when pending and no load accepted that cycle; SWEEP updates object idx=0..N_OBJ-1, one per cycle, then returns to IDLE; sweep latency SHALL be exactly N_OBJ cycles; pending SHALL clear on entry to SWEEP.
REQ-015 busy SHALL be high exactly in SWEEP; load_ready SHALL be high exactly in IDLE.
REQ-016 A load SHALL occur when load_valid and load_ready are both high: it writes x, y, vx, vy of load_idx and clears obj_hit[load_idx]; load wins over a simultaneous pending tick, and the sweep starts the next cycle.
REQ-017 A tick during SWEEP SHALL set pending and start a new sweep immediately after the current one ends; a second tick while pending is already set SHALL be dropped.
REQ-018 mode, sel and keycode SHALL be captured on entry to SWEEP and held for the whole sweep.
REQ-019 Mode 0, selected object: keycode 0x1A sets vy=-STEP, 0x16 sets vy=+STEP, 0x04 sets vx=-STEP, 0x07 sets vx=+STEP, and any other code leaves velocity unchanged; unselected objects keep their velocity.
REQ-020 Mode 0 bounce: next = pos + v, computed at COORD_W+2 bits signed; if next > MAX, pos=MAX, v=-v and hit set; if next < 0, pos=0, v=-v and hit set.
REQ-021 Mode 1 gravity: vy = min(vy+GRAVITY, MAX_FALL); if the selected object had a flap event since its last update, vy=FLAP_VEL instead; x moves by vx with no bounce and clamps at 0/X_MAX.
REQ-022 A flap event SHALL be a keycode transition to 0x2C (space). It is latched until the selected object's next update; a held key SHALL NOT re-flap.
REQ-023 Mode 1 floor/ceiling: if next y >= Y_MAX, y=Y_MAX, vy=0 and hit set; if next y < 0, y=0 and vy=0, with no hit.
REQ-024 obj_hit bits SHALL stay set until a load to that object or reset.

Reset
REQ-025 Reset_n low SHALL force, immediately: state IDLE, pending 0, flap latch 0, all obj_x=X_MAX/2 (319), obj_y=Y_MAX/2 (239), all velocities 0, obj_hit 0, busy 0, load_ready 0 while asserted.
REQ-026 Reset asserted mid-sweep SHALL abandon the sweep; the first cycle after release is IDLE, with no spurious tick from the vs edge detector, whose register resets to 1.

Structure
REQ-027 Keycode constants (0x1A, 0x16, 0x04, 0x07, 0x2C) and the state enum SHALL live in shared package game_pkg.
REQ-028 Per-object next-state arithmetic SHALL be one combinational sub-module, motion_step, instantiated once and time-shared across the sweep.

Verification
REQ-029 Reset, then one vs edge, N_OBJ=4: busy high for exactly 4 cycles, and all objects stay at (319,239).
REQ-030 Mode 0, sel=1, keycode 0x07, 3 ticks: obj1 x=325; other objects unchanged.
REQ-031 Mode 0, load obj2 x=638 vx=+2, one tick: x=639, vx=-2, obj_hit[2]=1; the next tick gives x=637.
REQ-032 Mode 1, obj0 y=100 vy=0, space pressed and held over 2 ticks: tick1 y=92 (vy=-8); tick2 y=85 (vy=-7, no re-flap).
REQ-033 load_valid in the same cycle as a vs edge: load accepted, busy rises the next cycle, and the sweep uses the loaded values.
REQ-034 Reset_n pulsed low during cycle 2 of a sweep: outputs return to reset values, and no sweep runs until the next vs edge.
